// File: rtl/seven_segment_scroller.sv
// ---------------------------------------------------------------------------
// seven_segment_scroller
//
// Message buffer and scan driver for a multiplexed seven-segment display.
// Upstream writes a word as a run of abcdefgh glyphs over a valid/ready
// port. Once the word is complete the block scans the glyphs across the
// digits and can scroll them leftwards, with `gap` blank positions inserted
// between repetitions.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   clear      synchronous: discard the message and return to LOAD
//   wr_valid   glyph write request
//   wr_ready   high while a glyph can be accepted (LOAD state)
//   wr_data    glyph pattern, bit7 = a ... bit0 = h, 1 = segment on
//   wr_last    marks the final glyph of the message
//   scroll_en  1 = scroll, 0 = hold the current offset
//   busy       high while the message is being shown
//   abcdefgh   segment pattern for the active digit, active-high
//   digit      one-hot active digit, bit w_digit-1 = leftmost (position 0)
// ---------------------------------------------------------------------------
module seven_segment_scroller #(
  parameter int w_digit       = 8,
  parameter int msg_depth     = 16,
  parameter int gap           = 2,
  parameter int scan_cycles   = 4096,
  parameter int scroll_cycles = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [7:0]         wr_data,
  input  logic               wr_last,
  input  logic               scroll_en,
  output logic               busy,
  output logic [7:0]         abcdefgh,
  output logic [w_digit-1:0] digit
);

  localparam int AW  = $clog2(msg_depth);
  localparam int LW  = AW + 1;
  // Wide enough for offset + position before the modulo reduction.
  localparam int IW  = $clog2(msg_depth + gap + 2 * w_digit) + 1;
  localparam int PW  = $clog2(w_digit) + 1;
  localparam int SCW = $clog2(scan_cycles);
  localparam int RCW = $clog2(scroll_cycles);

  typedef enum logic {LOAD, SHOW} state_t;

  state_t             state_q, state_d;
  logic [LW-1:0]      len_q, len_d;
  logic [IW-1:0]      offset_q, offset_d;
  logic [RCW-1:0]     scroll_cnt_q, scroll_cnt_d;
  logic [SCW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [w_digit-1:0] digit_q, digit_d;
  logic [7:0]         seg_q, seg_d;
  logic [7:0]         buf_q [msg_depth];

  logic               wr_fire;
  logic [IW-1:0]      win_len;
  logic [IW-1:0]      pos_ext;
  logic [IW-1:0]      idx;

  assign wr_ready = (state_q == LOAD);
  assign busy     = (state_q == SHOW);
  assign abcdefgh = seg_q;
  assign digit    = digit_q;

  // clear wins over a simultaneous handshake, so the glyph is never stored.
  assign wr_fire  = wr_ready && wr_valid && !clear;
  assign win_len  = IW'(len_q) + IW'(gap);

  // Message / scroll control
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    offset_d     = offset_q;
    scroll_cnt_d = scroll_cnt_q;
    if (clear) begin
      state_d      = LOAD;
      len_d        = '0;
      offset_d     = '0;
      scroll_cnt_d = '0;
    end else if (state_q == LOAD) begin
      if (wr_valid) begin
        len_d = len_q + LW'(1);
        if (wr_last || len_d == LW'(msg_depth)) begin
          state_d      = SHOW;
          offset_d     = '0;
          scroll_cnt_d = '0;
        end
      end
    end else if (scroll_en) begin
      if (scroll_cnt_q == RCW'(scroll_cycles - 1)) begin
        scroll_cnt_d = '0;
        offset_d     = (offset_q + IW'(1) >= win_len) ? '0 : offset_q + IW'(1);
      end else begin
        scroll_cnt_d = scroll_cnt_q + RCW'(1);
      end
    end
  end

  // Digit scan: pos tracks the set digit bit (pos 0 = leftmost)
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCW'(1);
    pos_d      = pos_q;
    digit_d    = digit_q;
    if (scan_cnt_q == SCW'(scan_cycles - 1)) begin
      scan_cnt_d = '0;
      pos_d      = (pos_q == PW'(w_digit - 1)) ? '0 : pos_q + PW'(1);
      digit_d    = {digit_q[0], digit_q[w_digit-1:1]};
    end
  end

  // Segment content is looked up for the *next* digit so that the registered
  // abcdefgh and digit outputs always change together.
  always_comb begin
    pos_ext = IW'(pos_d);
    idx     = offset_q + pos_ext;
    // offset < L and pos < w_digit, so at most w_digit subtractions reduce
    // idx into 0..L-1.
    for (int k = 0; k <= w_digit; k++) begin
      if (win_len != '0 && idx >= win_len) begin
        idx = idx - win_len;
      end
    end
    seg_d = '0;
    if (state_q == SHOW) begin
      if (!scroll_en && offset_q == '0) begin
        if (pos_ext < IW'(len_q)) begin
          seg_d = buf_q[pos_ext[AW-1:0]];
        end
      end else if (idx < IW'(len_q)) begin
        seg_d = buf_q[idx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      len_q        <= '0;
      offset_q     <= '0;
      scroll_cnt_q <= '0;
      scan_cnt_q   <= '0;
      pos_q        <= '0;
      digit_q      <= {1'b1, {(w_digit-1){1'b0}}};
      seg_q        <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      offset_q     <= offset_d;
      scroll_cnt_q <= scroll_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      pos_q        <= pos_d;
      digit_q      <= digit_d;
      seg_q        <= seg_d;
    end
  end

  // Glyph storage; stale entries beyond len are masked by the lookup.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      buf_q[len_q[AW-1:0]] <= wr_data;
    end
  end

endmodule
